bus_reg_slice: RTL and testbench

// - Registered pipeline stage placed directly in front of a bus pass-through

---
 rtl/bus_reg_slice_pkg.sv | 37 +++
 rtl/bus_reg_slice_if.sv | 29 ++
 rtl/bus_reg_slice_skid_buffer.sv | 79 +++++++
 rtl/bus_reg_slice.sv | 86 ++++++++
 tb/tb_bus_reg_slice.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_reg_slice_pkg.sv
// Shared bus encodings and beat structures for the registered bus slice.
package bus_reg_slice_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_BE_W   = BUS_DATA_W / 8;

  typedef enum logic [2:0] {
    MCMD_IDLE = 3'd0,
    MCMD_WR   = 3'd1,
    MCMD_RD   = 3'd2
  } mcmd_e;

  typedef enum logic [1:0] {
    SRESP_NULL = 2'd0,
    SRESP_DVA  = 2'd1
  } sresp_e;

  typedef struct packed {
    mcmd_e                 cmd;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] data;
    logic [BUS_BE_W-1:0]   byteen;
  } Bus_cmd_t;

  typedef struct packed {
    sresp_e                resp;
    logic [BUS_DATA_W-1:0] data;
  } Bus_resp_t;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_FULL
  } skid_state_e;

endpackage

// File: rtl/bus_reg_slice_if.sv
// Point-to-point bus: command channel (master->slave), response channel back.
interface Bus_if
  import bus_reg_slice_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BUS_ADDR_W,
  parameter int unsigned DATA_WIDTH = BUS_DATA_W
) ();

  mcmd_e                     MCmd;
  logic [ADDR_WIDTH-1:0]     MAddr;
  logic [DATA_WIDTH-1:0]     MData;
  logic [DATA_WIDTH/8-1:0]   MByteEn;
  logic                      SCmdAccept;
  sresp_e                    SResp;
  logic [DATA_WIDTH-1:0]     SData;
  logic                      MRespAccept;
  logic                      MReset_n;

  modport master (
    output MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n,
    input  SCmdAccept, SResp, SData
  );

  modport slave (
    input  MCmd, MAddr, MData, MByteEn, MRespAccept, MReset_n,
    output SCmdAccept, SResp, SData
  );

endinterface

// File: rtl/bus_reg_slice_skid_buffer.sv
// Two-entry skid buffer: ready comes from the state flop only, data from the main reg.
module skid_buffer
  import bus_reg_slice_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state, state_next;
  logic [WIDTH-1:0] main_q, main_next;
  logic [WIDTH-1:0] skid_q, skid_next;
  logic             push, pop;

  assign in_ready  = (state != SKID_FULL);
  assign out_valid = (state != SKID_EMPTY);
  assign out_data  = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      state  <= SKID_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_next;
      main_q <= main_next;
      skid_q <= skid_next;
    end
  end

  // Main is zeroed on draining so idle outputs read as all-zero payload.
  always_comb begin
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    unique case (state)
      SKID_EMPTY: begin
        if (push) begin
          main_next  = in_data;
          state_next = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          main_next = in_data;
        end else if (push) begin
          skid_next  = in_data;
          state_next = SKID_FULL;
        end else if (pop) begin
          main_next  = '0;
          state_next = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          main_next  = skid_q;
          skid_next  = '0;
          state_next = SKID_ONE;
        end
      end
      default: begin
        state_next = SKID_EMPTY;
        main_next  = '0;
        skid_next  = '0;
      end
    endcase
  end

endmodule

// File: rtl/bus_reg_slice.sv
// Fully registered bus pipeline stage: one skid buffer per channel, no comb path through.
module bus_reg_slice
  import bus_reg_slice_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BUS_ADDR_W,
  parameter int unsigned DATA_WIDTH = BUS_DATA_W
) (
  input  logic  clk,
  input  logic  reset_n,
  Bus_if.slave  in,
  Bus_if.master out
);

  Bus_cmd_t  cmd_push, cmd_main;
  Bus_resp_t resp_push, resp_main;
  logic      cmd_valid, cmd_ready, cmd_out_valid;
  logic      resp_valid, resp_ready, resp_out_valid;
  logic      flush;
  logic      mreset_q;

  logic [ADDR_WIDTH-1:0]   addr_out;
  logic [DATA_WIDTH-1:0]   data_out;
  logic [DATA_WIDTH/8-1:0] byteen_out;
  logic [DATA_WIDTH-1:0]   rdata_out;

  // Bus reset from the master clears both channels exactly like reset_n.
  assign flush = ~in.MReset_n;

  always_comb begin
    cmd_push.cmd    = in.MCmd;
    cmd_push.addr   = in.MAddr;
    cmd_push.data   = in.MData;
    cmd_push.byteen = in.MByteEn;
    resp_push.resp  = out.SResp;
    resp_push.data  = out.SData;
  end

  assign cmd_valid  = (in.MCmd != MCMD_IDLE);
  assign resp_valid = (out.SResp != SRESP_NULL);

  skid_buffer #(.WIDTH($bits(Bus_cmd_t))) u_cmd_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (cmd_valid),
    .in_ready  (cmd_ready),
    .in_data   (cmd_push),
    .out_valid (cmd_out_valid),
    .out_ready (out.SCmdAccept),
    .out_data  (cmd_main)
  );

  skid_buffer #(.WIDTH($bits(Bus_resp_t))) u_resp_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (resp_valid),
    .in_ready  (resp_ready),
    .in_data   (resp_push),
    .out_valid (resp_out_valid),
    .out_ready (in.MRespAccept),
    .out_data  (resp_main)
  );

  assign addr_out   = cmd_main.addr;
  assign data_out   = cmd_main.data;
  assign byteen_out = cmd_main.byteen;
  assign rdata_out  = resp_main.data;

  always_comb begin
    in.SCmdAccept   = cmd_ready;
    out.MCmd        = cmd_out_valid ? cmd_main.cmd : MCMD_IDLE;
    out.MAddr       = addr_out;
    out.MData       = data_out;
    out.MByteEn     = byteen_out;
    out.MRespAccept = resp_ready;
    in.SResp        = resp_out_valid ? resp_main.resp : SRESP_NULL;
    in.SData        = rdata_out;
    out.MReset_n    = mreset_q;
  end

  always_ff @(posedge clk) begin
    mreset_q <= reset_n & in.MReset_n;
  end

endmodule

// File: tb/tb_bus_reg_slice.sv
// Directed plus randomised scoreboard bench for bus_reg_slice.
module tb_bus_reg_slice;
  import bus_reg_slice_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  Bus_if bi ();
  Bus_if bo ();

  bus_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (bi),
    .out     (bo)
  );

  always #5 clk = ~clk;

  logic [63:0] cq[$];
  logic [31:0] rq[$];
  logic [63:0] c_prev;
  logic [31:0] r_prev;
  logic        c_stall_prev, r_stall_prev;
  logic [63:0] exp_c;
  logic [31:0] exp_r;
  logic [31:0] ca, cd, rdat;
  logic        cv, rv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input mcmd_e c, input logic [31:0] a, input logic [31:0] d);
    bi.MCmd    = c;
    bi.MAddr   = a;
    bi.MData   = d;
    bi.MByteEn = (c == MCMD_IDLE) ? 4'h0 : 4'hF;
  endtask

  task automatic drive_resp(input sresp_e r, input logic [31:0] d);
    bo.SResp = r;
    bo.SData = d;
  endtask

  initial begin
    reset_n        = 1'b0;
    bi.MReset_n    = 1'b1;
    bi.MRespAccept = 1'b1;
    bo.SCmdAccept  = 1'b1;
    drive_cmd(MCMD_IDLE, 32'h0, 32'h0);
    drive_resp(SRESP_NULL, 32'h0);

    // Reset state
    tick();
    tick();
    check("rst_cmd_accept", bi.SCmdAccept, 1);
    check("rst_resp_accept", bo.MRespAccept, 1);
    check("rst_mcmd", bo.MCmd, MCMD_IDLE);
    check("rst_sresp", bi.SResp, SRESP_NULL);
    check("rst_maddr", bo.MAddr, 0);
    check("rst_sdata", bi.SData, 0);
    check("rst_mreset", bo.MReset_n, 0);
    reset_n = 1'b1;
    tick();
    check("rst_mreset_release", bo.MReset_n, 1);

    // Single read, 1-cycle latency
    drive_cmd(MCMD_RD, 32'h100, 32'h0);
    check("rd_accept", bi.SCmdAccept, 1);
    tick();
    drive_cmd(MCMD_IDLE, 32'h0, 32'h0);
    check("rd_mcmd", bo.MCmd, MCMD_RD);
    check("rd_maddr", bo.MAddr, 32'h100);
    check("rd_accept_hold", bi.SCmdAccept, 1);
    tick();
    check("rd_drained", bo.MCmd, MCMD_IDLE);
    check("rd_drained_addr", bo.MAddr, 0);

    // Eight back-to-back writes
    for (int i = 0; i < 8; i++) begin
      drive_cmd(MCMD_WR, 32'h200 + 32'(i * 4), 32'(i));
      check("b2b_accept", bi.SCmdAccept, 1);
      tick();
      check("b2b_mcmd", bo.MCmd, MCMD_WR);
      check("b2b_data", bo.MData, 64'(i));
      check("b2b_addr", bo.MAddr, 64'(32'h200 + 32'(i * 4)));
      check("b2b_byteen", bo.MByteEn, 4'hF);
    end
    drive_cmd(MCMD_IDLE, 32'h0, 32'h0);
    tick();
    check("b2b_drained", bo.MCmd, MCMD_IDLE);

    // Downstream stall for 4 edges
    bo.SCmdAccept = 1'b0;
    drive_cmd(MCMD_WR, 32'h10, 32'h10);
    check("stall_acc_a", bi.SCmdAccept, 1);
    tick();
    check("stall_out_a", bo.MData, 32'h10);
    drive_cmd(MCMD_WR, 32'h11, 32'h11);
    check("stall_acc_b", bi.SCmdAccept, 1);
    tick();
    drive_cmd(MCMD_WR, 32'h12, 32'h12);
    check("stall_full_acc", bi.SCmdAccept, 0);
    check("stall_hold1", bo.MData, 32'h10);
    tick();
    check("stall_acc_c", bi.SCmdAccept, 0);
    check("stall_hold2", bo.MData, 32'h10);
    tick();
    check("stall_hold3", bo.MData, 32'h10);
    check("stall_hold3_cmd", bo.MCmd, MCMD_WR);
    bo.SCmdAccept = 1'b1;
    tick();
    check("stall_rel_b", bo.MData, 32'h11);
    check("stall_rel_acc", bi.SCmdAccept, 1);
    tick();
    drive_cmd(MCMD_IDLE, 32'h0, 32'h0);
    check("stall_rel_c", bo.MData, 32'h12);
    tick();
    check("stall_drained", bo.MCmd, MCMD_IDLE);

    // Response path with toggling MRespAccept
    bi.MRespAccept = 1'b1;
    drive_resp(SRESP_DVA, 32'hDEADBEEF);
    check("resp_acc0", bo.MRespAccept, 1);
    tick();
    check("resp_r0", bi.SData, 32'hDEADBEEF);
    check("resp_r0_type", bi.SResp, SRESP_DVA);
    bi.MRespAccept = 1'b0;
    drive_resp(SRESP_DVA, 32'hDEADBEF0);
    tick();
    drive_resp(SRESP_NULL, 32'h0);
    check("resp_full_acc", bo.MRespAccept, 0);
    check("resp_r0_hold", bi.SData, 32'hDEADBEEF);
    bi.MRespAccept = 1'b1;
    tick();
    check("resp_r1", bi.SData, 32'hDEADBEF0);
    check("resp_acc_back", bo.MRespAccept, 1);
    bi.MRespAccept = 1'b0;
    tick();
    check("resp_r1_hold", bi.SData, 32'hDEADBEF0);
    bi.MRespAccept = 1'b1;
    tick();
    check("resp_drained", bi.SResp, SRESP_NULL);
    check("resp_drained_data", bi.SData, 0);

    // Reset with both channels full
    bo.SCmdAccept  = 1'b0;
    bi.MRespAccept = 1'b0;
    drive_cmd(MCMD_WR, 32'h20, 32'h20);
    drive_resp(SRESP_DVA, 32'h50);
    tick();
    drive_cmd(MCMD_WR, 32'h21, 32'h21);
    drive_resp(SRESP_DVA, 32'h51);
    tick();
    drive_cmd(MCMD_IDLE, 32'h0, 32'h0);
    drive_resp(SRESP_NULL, 32'h0);
    check("full_cmd_acc", bi.SCmdAccept, 0);
    check("full_resp_acc", bo.MRespAccept, 0);
    reset_n = 1'b0;
    tick();
    check("mrst_mcmd", bo.MCmd, MCMD_IDLE);
    check("mrst_sresp", bi.SResp, SRESP_NULL);
    check("mrst_cmd_acc", bi.SCmdAccept, 1);
    check("mrst_resp_acc", bo.MRespAccept, 1);
    check("mrst_mreset", bo.MReset_n, 0);
    check("mrst_maddr", bo.MAddr, 0);
    reset_n        = 1'b1;
    bo.SCmdAccept  = 1'b1;
    bi.MRespAccept = 1'b1;
    tick();
    check("mrst_no_replay_cmd", bo.MCmd, MCMD_IDLE);
    check("mrst_no_replay_resp", bi.SResp, SRESP_NULL);

    // Bus reset via in.MReset_n flushes both channels
    bo.SCmdAccept  = 1'b0;
    bi.MRespAccept = 1'b0;
    drive_cmd(MCMD_WR, 32'h300, 32'h33);
    drive_resp(SRESP_DVA, 32'h55);
    tick();
    drive_cmd(MCMD_IDLE, 32'h0, 32'h0);
    drive_resp(SRESP_NULL, 32'h0);
    check("brst_pre_cmd", bo.MCmd, MCMD_WR);
    check("brst_pre_resp", bi.SData, 32'h55);
    bi.MReset_n = 1'b0;
    tick();
    check("brst_mcmd", bo.MCmd, MCMD_IDLE);
    check("brst_mdata", bo.MData, 0);
    check("brst_sresp", bi.SResp, SRESP_NULL);
    check("brst_mreset", bo.MReset_n, 0);
    check("brst_cmd_acc", bi.SCmdAccept, 1);
    bi.MReset_n    = 1'b1;
    bo.SCmdAccept  = 1'b1;
    bi.MRespAccept = 1'b1;
    tick();
    check("brst_mreset_release", bo.MReset_n, 1);

    // Throughput with an always-accepting sink
    for (int k = 0; k < 32; k++) begin
      drive_cmd(MCMD_WR, 32'h1000 + 32'(k), 32'(k));
      check("tput_accept", bi.SCmdAccept, 1);
      if (k > 0) begin
        check("tput_mcmd", bo.MCmd, MCMD_WR);
        check("tput_data", bo.MData, 64'(k - 1));
      end
      tick();
    end
    drive_cmd(MCMD_IDLE, 32'h0, 32'h0);
    check("tput_last", bo.MData, 31);
    tick();
    check("tput_drained", bo.MCmd, MCMD_IDLE);

    // Random valid/accept on both channels with in-order scoreboard
    c_stall_prev = 1'b0;
    r_stall_prev = 1'b0;
    c_prev = '0;
    r_prev = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      cv   = ($urandom_range(0, 3) != 0);
      rv   = ($urandom_range(0, 3) != 0);
      ca   = $urandom;
      cd   = $urandom;
      rdat = $urandom;
      if (cv) drive_cmd(MCMD_WR, ca, cd);
      else    drive_cmd(MCMD_IDLE, 32'h0, 32'h0);
      if (rv) drive_resp(SRESP_DVA, rdat);
      else    drive_resp(SRESP_NULL, 32'h0);
      bo.SCmdAccept  = 1'($urandom_range(0, 1));
      bi.MRespAccept = 1'($urandom_range(0, 1));

      if (c_stall_prev) check("rnd_cmd_hold", {bo.MAddr, bo.MData}, c_prev);
      if (r_stall_prev) check("rnd_resp_hold", bi.SData, r_prev);

      if (bo.MCmd != MCMD_IDLE && bo.SCmdAccept) begin
        check("rnd_cmd_expected", 64'(cq.size() != 0), 1);
        if (cq.size() != 0) begin
          exp_c = cq.pop_front();
          check("rnd_cmd_order", {bo.MAddr, bo.MData}, exp_c);
          check("rnd_cmd_type", bo.MCmd, MCMD_WR);
        end
      end
      if (bi.SResp != SRESP_NULL && bi.MRespAccept) begin
        check("rnd_resp_expected", 64'(rq.size() != 0), 1);
        if (rq.size() != 0) begin
          exp_r = rq.pop_front();
          check("rnd_resp_order", bi.SData, exp_r);
        end
      end
      c_stall_prev = (bo.MCmd != MCMD_IDLE) && !bo.SCmdAccept;
      r_stall_prev = (bi.SResp != SRESP_NULL) && !bi.MRespAccept;
      c_prev = {bo.MAddr, bo.MData};
      r_prev = bi.SData;
      if (cv && bi.SCmdAccept) cq.push_back({ca, cd});
      if (rv && bo.MRespAccept) rq.push_back(rdat);
      tick();
      check("rnd_cmd_occupancy", 64'(cq.size() <= 2), 1);
      check("rnd_resp_occupancy", 64'(rq.size() <= 2), 1);
    end

    // Drain whatever is left and confirm nothing is lost
    drive_cmd(MCMD_IDLE, 32'h0, 32'h0);
    drive_resp(SRESP_NULL, 32'h0);
    bo.SCmdAccept  = 1'b1;
    bi.MRespAccept = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (bo.MCmd != MCMD_IDLE) begin
        check("drain_cmd_expected", 64'(cq.size() != 0), 1);
        if (cq.size() != 0) begin
          exp_c = cq.pop_front();
          check("drain_cmd_order", {bo.MAddr, bo.MData}, exp_c);
        end
      end
      if (bi.SResp != SRESP_NULL) begin
        check("drain_resp_expected", 64'(rq.size() != 0), 1);
        if (rq.size() != 0) begin
          exp_r = rq.pop_front();
          check("drain_resp_order", bi.SData, exp_r);
        end
      end
      tick();
    end
    check("drain_cmd_empty", 64'(cq.size()), 0);
    check("drain_resp_empty", 64'(rq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
